// File: rtl/dff_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : dff_pipe
//  Description : Elastic pipeline of depth_p register stages with valid/ready
//                handshake, bubble collapsing and synchronous flush.
//  Revision    : 1.0 - initial release
// ============================================================================
module dff_pipe #(
    parameter int                 width_p     = 32,
    parameter int                 depth_p     = 2,
    parameter logic [width_p-1:0] reset_val_p = '0
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           flush_i,
    input  logic                           v_i,
    output logic                           ready_o,
    input  logic [width_p-1:0]             i,
    output logic                           v_o,
    input  logic                           ready_i,
    output logic [width_p-1:0]             o,
    output logic [$clog2(depth_p+1)-1:0]   count_o
);

    localparam int                 c_cnt_w   = $clog2(depth_p + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);

    logic [depth_p-1:0] r_v;
    logic [width_p-1:0] r_data [depth_p];
    logic [c_cnt_w-1:0] r_count;

    logic [depth_p-1:0] w_adv;
    logic [depth_p-1:0] w_free;
    logic               w_in_hs;
    logic               w_out_hs;

    // Advance/free chain, walked from the output stage back to stage 0:
    // a stage may move forward when the stage ahead of it is free.
    always_comb begin
        logic w_go;
        w_adv  = '0;
        w_free = '0;
        w_go   = ready_i;
        for (int k = depth_p - 1; k >= 0; k--) begin
            w_adv[k]  = r_v[k] & w_go;
            w_free[k] = ~r_v[k] | w_adv[k];
            w_go      = w_free[k];
        end
    end

    assign ready_o  = w_free[0] & ~flush_i & ~rst_i;
    assign w_in_hs  = v_i & ready_o;
    assign w_out_hs = r_v[depth_p-1] & ready_i;

    // Valid bits: set by a transfer in, cleared when the word leaves and
    // nothing replaces it; a flush empties every stage.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_v <= '0;
        end else if (flush_i) begin
            r_v <= '0;
        end else begin
            r_v[0] <= w_in_hs | (r_v[0] & ~w_adv[0]);
            for (int k = 1; k < depth_p; k++) begin
                r_v[k] <= w_adv[k-1] | (r_v[k] & ~w_adv[k]);
            end
        end
    end

    // Data registers load only on a transfer and otherwise hold, so stale
    // data stays visible on invalid stages (including through a flush).
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int k = 0; k < depth_p; k++) begin
                r_data[k] <= reset_val_p;
            end
        end else begin
            if (w_in_hs) begin
                r_data[0] <= i;
            end
            for (int k = 1; k < depth_p; k++) begin
                if (w_adv[k-1] & ~flush_i) begin
                    r_data[k] <= r_data[k-1];
                end
            end
        end
    end

    // Occupancy: +1 per accepted word, -1 per delivered word.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_count <= '0;
        end else if (flush_i) begin
            r_count <= '0;
        end else if (w_in_hs & ~w_out_hs) begin
            r_count <= r_count + c_cnt_one;
        end else if (~w_in_hs & w_out_hs) begin
            r_count <= r_count - c_cnt_one;
        end
    end

    assign v_o     = r_v[depth_p-1];
    assign o       = r_data[depth_p-1];
    assign count_o = r_count;

endmodule
`default_nettype wire

// File: tb/tb_dff_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dff_pipe
//  Description : Self-checking bench for dff_pipe (depth 3 and depth 1).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dff_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        v_in;
    logic        rdy_in;
    logic [15:0] din;

    logic        r3_ready, r3_v;
    logic [15:0] r3_o;
    logic [1:0]  r3_cnt;
    logic        r1_ready, r1_v;
    logic [15:0] r1_o;
    logic [0:0]  r1_cnt;

    int          sel;
    logic        m_ready, m_v;
    logic [15:0] m_o;
    int          m_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] qd[$];
    int          qp[$];

    always #5 clk = ~clk;

    dff_pipe #(.width_p(16), .depth_p(3), .reset_val_p(16'd5)) u_dut3 (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .v_i(v_in), .ready_o(r3_ready),
        .i(din), .v_o(r3_v), .ready_i(rdy_in), .o(r3_o), .count_o(r3_cnt)
    );

    dff_pipe #(.width_p(16), .depth_p(1), .reset_val_p(16'd5)) u_dut1 (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .v_i(v_in), .ready_o(r1_ready),
        .i(din), .v_o(r1_v), .ready_i(rdy_in), .o(r1_o), .count_o(r1_cnt)
    );

    always_comb begin
        m_ready = (sel == 1) ? r1_ready : r3_ready;
        m_v     = (sel == 1) ? r1_v     : r3_v;
        m_o     = (sel == 1) ? r1_o     : r3_o;
        m_cnt   = (sel == 1) ? int'(r1_cnt) : int'(r3_cnt);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic        fl, v, rdy;
        logic [15:0] din;
        logic        e_rdy, e_v;
        logic [15:0] e_o;
        int          e_cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic fl, input logic v, input logic rdy, input logic [15:0] d,
                       input logic e_rdy, input logic e_v, input logic [15:0] e_o, input int e_cnt);
        vec_t t;
        t.fl = fl; t.v = v; t.rdy = rdy; t.din = d;
        t.e_rdy = e_rdy; t.e_v = e_v; t.e_o = e_o; t.e_cnt = e_cnt;
        vecs.push_back(t);
    endtask

    // Random traffic checked against a queue of (word, stage position) items.
    task automatic run_random(input int dep, input int s);
        int  n, p, prev_before;
        bit  mv, prev_moved, leave, e_rdy, e_v;
        sel = s;
        @(posedge clk); #1;
        rst = 1'b1; flush = 1'b0; v_in = 1'b0; rdy_in = 1'b0;
        #2 rst = 1'b0;
        qd.delete(); qp.delete();
        for (int it = 0; it < 10000; it++) begin
            @(posedge clk); #1;
            if (rst) rst = 1'b0;
            flush  = ($urandom_range(0, 63) == 0);
            v_in   = ($urandom_range(0, 3) != 0);
            rdy_in = ($urandom_range(0, 2) != 0);
            din    = 16'($urandom);
            #4;
            n     = qd.size();
            e_rdy = !flush && (n < dep || rdy_in);
            e_v   = (n > 0) && (qp[0] == dep - 1);
            chk($sformatf("rand d%0d ready_o", dep), {31'd0, m_ready}, {31'd0, e_rdy});
            chk($sformatf("rand d%0d v_o", dep), {31'd0, m_v}, {31'd0, e_v});
            chk($sformatf("rand d%0d count_o", dep), m_cnt, n);
            if (e_v && rdy_in)
                chk($sformatf("rand d%0d o", dep), {16'd0, m_o}, {16'd0, qd[0]});
            if (flush) begin
                qd.delete(); qp.delete();
            end else begin
                leave = 1'b0; prev_before = 0; prev_moved = 1'b0;
                for (int k = 0; k < qp.size(); k++) begin
                    p = qp[k];
                    if (k == 0) begin
                        if (p == dep - 1) begin
                            mv = rdy_in; leave = rdy_in;
                        end else begin
                            mv = 1'b1;
                        end
                    end else begin
                        mv = (prev_before > p + 1) || prev_moved;
                    end
                    prev_before = p; prev_moved = mv;
                    if (mv && !(k == 0 && leave)) qp[k] = p + 1;
                end
                if (leave) begin
                    void'(qd.pop_front()); void'(qp.pop_front());
                end
                if (v_in && e_rdy) begin
                    qd.push_back(din); qp.push_back(0);
                end
            end
            if (it % 2500 == 1237) begin
                #2 rst = 1'b1;
                #1;
                chk($sformatf("async rst d%0d v_o", dep), {31'd0, m_v}, 32'd0);
                chk($sformatf("async rst d%0d o", dep), {16'd0, m_o}, 32'd5);
                chk($sformatf("async rst d%0d count_o", dep), m_cnt, 0);
                chk($sformatf("async rst d%0d ready_o", dep), {31'd0, m_ready}, 32'd0);
                qd.delete(); qp.delete();
            end
        end
    endtask

    initial begin
        sel = 0; rst = 1'b1; flush = 1'b0; v_in = 1'b1; rdy_in = 1'b1; din = 16'h7777;
        #3;
        for (int s = 0; s < 2; s++) begin
            sel = s;
            #1;
            chk($sformatf("reset s%0d v_o", s), {31'd0, m_v}, 32'd0);
            chk($sformatf("reset s%0d o", s), {16'd0, m_o}, 32'd5);
            chk($sformatf("reset s%0d count_o", s), m_cnt, 0);
            chk($sformatf("reset s%0d ready_o", s), {31'd0, m_ready}, 32'd0);
        end
        sel = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0; v_in = 1'b0;

        // fl v rdy din | ready v_o o cnt
        add(0,1,1,16'h1234, 1,0,16'h0005,0);
        add(0,0,1,16'h0000, 1,0,16'h0005,1);
        add(0,0,1,16'h0000, 1,0,16'h0005,1);
        add(0,0,1,16'h0000, 1,1,16'h1234,1);
        add(0,1,1,16'h0001, 1,0,16'h1234,0);
        add(0,1,1,16'h0002, 1,0,16'h1234,1);
        add(0,1,1,16'h0003, 1,0,16'h1234,2);
        add(0,1,1,16'h0004, 1,1,16'h0001,3);
        add(0,1,1,16'h0005, 1,1,16'h0002,3);
        add(0,1,1,16'h0006, 1,1,16'h0003,3);
        add(0,1,1,16'h0007, 1,1,16'h0004,3);
        add(0,1,1,16'h0008, 1,1,16'h0005,3);
        add(0,0,1,16'h0000, 1,1,16'h0006,3);
        add(0,0,1,16'h0000, 1,1,16'h0007,2);
        add(0,0,1,16'h0000, 1,1,16'h0008,1);
        add(0,1,0,16'h00A1, 1,0,16'h0008,0);
        add(0,1,0,16'h00A2, 1,0,16'h0008,1);
        add(0,1,0,16'h00A3, 1,0,16'h0008,2);
        add(0,1,0,16'h00A4, 0,1,16'h00A1,3);
        add(0,1,1,16'h00A4, 1,1,16'h00A1,3);
        add(0,0,0,16'h0000, 0,1,16'h00A2,3);
        add(0,0,1,16'h0000, 1,1,16'h00A2,3);
        add(0,0,1,16'h0000, 1,1,16'h00A3,2);
        add(0,0,1,16'h0000, 1,1,16'h00A4,1);
        add(0,1,0,16'h00B1, 1,0,16'h00A4,0);
        add(0,0,0,16'h0000, 1,0,16'h00A4,1);
        add(0,0,0,16'h0000, 1,0,16'h00A4,1);
        add(0,1,0,16'h00B2, 1,1,16'h00B1,1);
        add(0,0,0,16'h0000, 1,1,16'h00B1,2);
        add(0,0,0,16'h0000, 1,1,16'h00B1,2);
        add(0,0,1,16'h0000, 1,1,16'h00B1,2);
        add(0,0,1,16'h0000, 1,1,16'h00B2,1);
        add(0,1,0,16'h00C1, 1,0,16'h00B2,0);
        add(0,1,0,16'h00C2, 1,0,16'h00B2,1);
        add(1,1,0,16'h00C3, 0,0,16'h00B2,2);
        add(0,0,0,16'h0000, 1,0,16'h00B2,0);
        add(0,1,1,16'h00D1, 1,0,16'h00B2,0);
        add(0,0,1,16'h0000, 1,0,16'h00B2,1);
        add(0,0,1,16'h0000, 1,0,16'h00B2,1);
        add(0,0,1,16'h0000, 1,1,16'h00D1,1);
        add(0,0,1,16'h0000, 1,0,16'h00D1,0);
        add(0,1,0,16'h00E1, 1,0,16'h00D1,0);
        add(0,0,0,16'h0000, 1,0,16'h00D1,1);
        add(0,0,0,16'h0000, 1,0,16'h00D1,1);
        add(1,1,1,16'h00E2, 0,1,16'h00E1,1);
        add(0,0,1,16'h0000, 1,0,16'h00E1,0);

        for (int r = 0; r < vecs.size(); r++) begin
            @(posedge clk); #1;
            flush = vecs[r].fl; v_in = vecs[r].v; rdy_in = vecs[r].rdy; din = vecs[r].din;
            #4;
            chk($sformatf("vec%0d ready_o", r), {31'd0, m_ready}, {31'd0, vecs[r].e_rdy});
            chk($sformatf("vec%0d v_o", r), {31'd0, m_v}, {31'd0, vecs[r].e_v});
            chk($sformatf("vec%0d o", r), {16'd0, m_o}, {16'd0, vecs[r].e_o});
            chk($sformatf("vec%0d count_o", r), m_cnt, vecs[r].e_cnt);
        end

        run_random(3, 0);
        run_random(1, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dff_pipe.md
Name: dff_pipe

Overview:
- Parametrised successor to the single-stage dff: an elastic pipeline of depth_p register stages with a valid/ready handshake, bubble collapsing and synchronous flush.
- Used wherever the core needs a multi-cycle, stallable datapath delay, for example between fetch/decode/execute stages or around slow functional units.
- Each stage holds one width_p-bit word plus a valid bit.
- A stalled output backs up the pipe while empty stages keep filling.

Parameters:
width_p, 32, payload width in bits (>=1)
depth_p, 2, number of register stages (>=1)
reset_val_p, 0, value loaded into every stage's data register on reset

Ports:
clk_i  in  1  clock, all state on posedge
rst_i  in  1  reset, asynchronous, active-high; clears all state immediately
flush_i  in  1  synchronous flush: invalidates every stage at the next posedge
v_i  in  1  upstream word valid
ready_o  out  1  pipe can accept a word this cycle
i  in  width_p  upstream data
v_o  out  1  last stage holds a valid word
ready_i  in  1  downstream accepts the word on o this cycle
o  out  width_p  data register of last stage (depth_p-1)
count_o  out  $clog2(depth_p+1)  number of valid stages, 0..depth_p

Behaviour:
- Reset (rst_i=1, asynchronous):
  - All valid bits go to 0 and all data registers to reset_val_p.
  - Outputs: v_o=0, o=reset_val_p, count_o=0, ready_o=0 while rst_i is high.
  - Deassertion takes effect at the next posedge.
- Stage indexing: stage 0 is the input side, stage depth_p-1 drives v_o/o.
- Advance rule, per stage k, evaluated combinationally:
  - adv[depth_p-1] = v[depth_p-1] & ready_i.
  - For k<depth_p-1: adv[k] = v[k] & (~v[k+1] | adv[k+1]).
  - free[k] = ~v[k] | adv[k].
- ready_o = free[0] & ~flush_i & ~rst_i. The combinational path from ready_i to ready_o is permitted and intended, giving full throughput with no bubble.
- Input handshake: a word is accepted when v_i & ready_o. Stage 0 loads i and sets v[0].
- Stage k+1 loads data[k] and sets v[k+1] when adv[k]. Stage k clears v[k] when adv[k] and it is not reloaded in the same cycle.
- Output handshake: the word is consumed when v_o & ready_i.
- Data registers load only on a transfer. Otherwise they hold, including when invalid, so o may show stale data while v_o=0.
- Latency: a word accepted in cycle c appears on o with v_o=1 in cycle c+depth_p when there are no stalls.
- Throughput: 1 word/cycle sustained while ready_i=1.
- Bubble collapse: a gap in v_i does not propagate as a stall. Later words move into empty stages even while ready_i=0 and stop only behind the last occupied stage.
- Full: when all depth_p stages are valid and ready_i=0, ready_o=0 and nothing moves.
- Full with ready_i=1: the whole pipe shifts and ready_o=1 in the same cycle.
- Flush (flush_i=1 at a posedge):
  - Every v[k] is cleared and count_o becomes 0 the next cycle; data registers hold.
  - ready_o=0 during a flush cycle, so no input is accepted.
  - An output handshake in the flush cycle (v_o & ready_i) still counts as delivered.
- count_o is updated every posedge: +1 on an input handshake, -1 on an output handshake, unchanged if both or neither, 0 after flush or reset.
- depth_p=1: a single stage; ready_o = ~v[0] | ready_i, with full throughput.
- Ordering: words leave in acceptance order. Nothing is dropped or duplicated except by flush or reset.

Test Plan:
1. width_p=16, depth_p=3, reset_val_p=5: hold rst_i, then release -> o=5, v_o=0, count_o=0. Accept 0x1234 in cycle c with ready_i=1 -> v_o=1, o=0x1234 in cycle c+3.
2. Stream 0x0001..0x0008 back to back with ready_i=1 -> ready_o stays 1, outputs appear in order with no gaps, count_o stays 3 in steady state.
3. Feed 3 words with ready_i=0 -> ready_o=0 after the third, count_o=3. Then raise ready_i for one cycle -> one word delivered, ready_o=1 that same cycle, and the fourth word is accepted concurrently.
4. Send a word, idle 2 cycles, then send another, with ready_i=0 -> both collapse to stages 2 and 1, count_o=2, and the second word is delivered the cycle after the first once ready_i=1.
5. Pipe holding 2 words, assert flush_i with v_i=1 -> ready_o=0, nothing accepted, next cycle v_o=0 and count_o=0, and o retains its last data.
6. Random v_i/ready_i, 10k cycles, with rst_i pulsed asynchronously mid-stream between clock edges -> v_o=0, o=5, count_o=0 immediately. A scoreboard queue model matches o on every output handshake, and depth_p=1 is rerun with the same checks.
